btn_conditioner: RTL

BTN_CONDITIONER -- requirements
Module: btn_conditioner

---
 rtl/breakout_pkg.sv | 14 +
 rtl/btn_debounce.sv | 66 ++++++
 rtl/btn_conditioner.sv | 70 +++++++
 3 files changed

// File: rtl/breakout_pkg.sv
// Shared types and screen constants for the breakout paddle input path.
package breakout_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_WAIT = 2'd3
  } btn_state_t;

  localparam int H_RES = 640;
  localparam int V_RES = 480;

endpackage

// File: rtl/btn_debounce.sv
// One button: 2-flop synchronizer, debounce FSM, registered level and press pulse.
// A clean raw edge reaches lvl DEBOUNCE_CYCLES+3 cycles later.
import breakout_pkg::*;

module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic pix_clk,
  input  logic reset_n,
  input  logic raw,
  output logic lvl,
  output logic press
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(DEBOUNCE_CYCLES);

  logic          sync_a;
  logic          sync_b;
  btn_state_t    state;
  btn_state_t    state_nxt;
  logic [CW-1:0] cnt;

  always_ff @(posedge pix_clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_a <= 1'b0;
      sync_b <= 1'b0;
    end else begin
      sync_a <= raw;
      sync_b <= sync_a;
    end
  end

  // Any opposite sample in a wait state abandons it, so re-entry restarts the count.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:         if (sync_b) state_nxt = PRESS_WAIT;
      PRESS_WAIT:   if (!sync_b) state_nxt = IDLE;
                    else if (cnt == CNT_LAST) state_nxt = HELD;
      HELD:         if (!sync_b) state_nxt = RELEASE_WAIT;
      RELEASE_WAIT: if (sync_b) state_nxt = HELD;
                    else if (cnt == CNT_LAST) state_nxt = IDLE;
      default:      state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge pix_clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      cnt   <= '0;
      lvl   <= 1'b0;
      press <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state_nxt != state)
        cnt <= '0;
      else if ((state == PRESS_WAIT || state == RELEASE_WAIT) && cnt != CNT_MAX)
        cnt <= cnt + 1'b1;
      lvl   <= (state_nxt == HELD) || (state_nxt == RELEASE_WAIT);
      press <= (state == PRESS_WAIT) && (state_nxt == HELD);
    end
  end

endmodule

// File: rtl/btn_conditioner.sv
// Debounces left/right buttons and latches paddle move/step once per frame tick.
// lvl/press follow raw edges after DEBOUNCE_CYCLES+3 cycles; move outputs change only on frame_tick.
import breakout_pkg::*;

module btn_conditioner #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int ACCEL_FRAMES    = 8,
  parameter int STEP_SLOW       = 4,
  parameter int STEP_FAST       = 8
) (
  input  logic       pix_clk,
  input  logic       reset_n,
  input  logic       btn_left_raw,
  input  logic       btn_right_raw,
  input  logic       frame_tick,
  output logic       left_lvl,
  output logic       right_lvl,
  output logic       left_press,
  output logic       right_press,
  output logic       mv_left,
  output logic       mv_right,
  output logic [3:0] pdl_step
);

  logic [3:0] hold_frames;
  logic       one_dir;
  logic       dir_change;
  logic [3:0] hold_eff;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_left (
    .pix_clk (pix_clk),
    .reset_n (reset_n),
    .raw     (btn_left_raw),
    .lvl     (left_lvl),
    .press   (left_press)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_right (
    .pix_clk (pix_clk),
    .reset_n (reset_n),
    .raw     (btn_right_raw),
    .lvl     (right_lvl),
    .press   (right_press)
  );

  // Reversing without an idle frame in between starts acceleration over.
  assign one_dir    = left_lvl ^ right_lvl;
  assign dir_change = (left_lvl & mv_right) | (right_lvl & mv_left);
  assign hold_eff   = dir_change ? 4'd0 : hold_frames;

  always_ff @(posedge pix_clk or negedge reset_n) begin
    if (!reset_n) begin
      mv_left     <= 1'b0;
      mv_right    <= 1'b0;
      pdl_step    <= 4'd0;
      hold_frames <= 4'd0;
    end else if (frame_tick) begin
      mv_left  <= left_lvl & ~right_lvl;
      mv_right <= right_lvl & ~left_lvl;
      if (one_dir) begin
        pdl_step    <= (int'(hold_eff) < ACCEL_FRAMES) ? 4'(STEP_SLOW) : 4'(STEP_FAST);
        hold_frames <= (hold_eff == 4'hF) ? 4'hF : hold_eff + 4'd1;
      end else begin
        pdl_step    <= 4'd0;
        hold_frames <= 4'd0;
      end
    end
  end

endmodule
